// File: rtl/memory32_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of memory32_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface memory32_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   // fetch requester
   logic                  fetch_req_valid;
   logic                  fetch_req_ready;
   logic [ADDR_WIDTH-1:0] fetch_req_addr;
   logic                  fetch_rsp_valid;
   logic [DATA_WIDTH-1:0] fetch_rsp_data;
   logic                  fetch_rsp_exception;

   // load/store requester
   logic                  data_req_valid;
   logic                  data_req_ready;
   logic [ADDR_WIDTH-1:0] data_req_addr;
   logic                  data_req_write;
   logic [DATA_WIDTH-1:0] data_req_wdata;
   logic [MASK_WIDTH-1:0] data_req_wmask;
   logic                  data_rsp_valid;
   logic [DATA_WIDTH-1:0] data_rsp_rdata;
   logic                  data_rsp_exception;

   // single memory port
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wen;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_exception;

   modport slave (
      input  fetch_req_valid, fetch_req_addr,
      input  data_req_valid, data_req_addr, data_req_write, data_req_wdata, data_req_wmask,
      input  mem_rdata, mem_exception,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_exception,
      output data_req_ready, data_rsp_valid, data_rsp_rdata, data_rsp_exception,
      output mem_addr, mem_wen, mem_wdata
   );

   modport master (
      output fetch_req_valid, fetch_req_addr,
      output data_req_valid, data_req_addr, data_req_write, data_req_wdata, data_req_wmask,
      output mem_rdata, mem_exception,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_exception,
      input  data_req_ready, data_rsp_valid, data_rsp_rdata, data_rsp_exception,
      input  mem_addr, mem_wen, mem_wdata
   );
endinterface

// File: rtl/memory32_port_arbiter.sv
// Round-robin arbiter sharing one memory32 port between fetch and data.
// One request in flight; sub-word stores are done as read-merge-write.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. ready only rises in IDLE, for the granted side, and
// never depends on ready of the other side. Responses are a one-cycle
// rsp_valid pulse with no backpressure; the requester must take it.
module memory32_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter bit STRICT_ALIGN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   memory32_port_arbiter_if.slave bus,
   output logic [1:0]           state_o
);
   localparam int MW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WRITE  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                state_q;
   logic                  last_grant_q;   // 1: data was granted last
   logic                  src_data_q;     // owner of the request in flight
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [MW-1:0]         wmask_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  mem_wen_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_exc_q;
   logic                  fetch_rsp_valid_q;
   logic                  data_rsp_valid_q;

   logic                  grant_fetch_d;
   logic                  grant_data_d;
   logic [ADDR_WIDTH-1:0] req_addr_d;
   logic                  misaligned_d;
   logic                  req_write_d;
   logic                  full_store_d;
   logic                  partial_d;
   logic [DATA_WIDTH-1:0] merged_d;

   // Grant: sole requester, or on a tie the side that was not granted last.
   always_comb begin
      grant_fetch_d = bus.fetch_req_valid && (!bus.data_req_valid || last_grant_q);
      grant_data_d  = bus.data_req_valid && !grant_fetch_d;
      req_addr_d    = grant_fetch_d ? bus.fetch_req_addr : bus.data_req_addr;
      misaligned_d  = STRICT_ALIGN && (req_addr_d[1:0] != 2'b00);
      req_write_d   = grant_data_d && bus.data_req_write;
      full_store_d  = req_write_d && (&bus.data_req_wmask);
      partial_d     = write_q && (wmask_q != '0) && !(&wmask_q);
   end

   // Byte merge of stored lanes over the word read in ACCESS.
   always_comb begin
      merged_d = '0;
      for (int b = 0; b < MW; b++) begin
         merged_d[b*8 +: 8] = wmask_q[b] ? wdata_q[b*8 +: 8] : bus.mem_rdata[b*8 +: 8];
      end
   end

   // Request/response FSM with registered memory-side and response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         last_grant_q      <= 1'b1;
         src_data_q        <= 1'b0;
         write_q           <= 1'b0;
         wdata_q           <= '0;
         wmask_q           <= '0;
         mem_addr_q        <= '0;
         mem_wen_q         <= 1'b0;
         mem_wdata_q       <= '0;
         rsp_data_q        <= '0;
         rsp_exc_q         <= 1'b0;
         fetch_rsp_valid_q <= 1'b0;
         data_rsp_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_fetch_d || grant_data_d) begin
                  last_grant_q <= grant_data_d;
                  src_data_q   <= grant_data_d;
                  write_q      <= req_write_d;
                  wdata_q      <= bus.data_req_wdata;
                  wmask_q      <= bus.data_req_wmask;
                  if (misaligned_d) begin
                     // fault without touching memory
                     rsp_data_q        <= '0;
                     rsp_exc_q         <= 1'b1;
                     fetch_rsp_valid_q <= grant_fetch_d;
                     data_rsp_valid_q  <= grant_data_d;
                     state_q           <= S_RESP;
                  end else begin
                     // a full-word store writes in ACCESS, so set it up now
                     mem_addr_q  <= {req_addr_d[ADDR_WIDTH-1:2], 2'b00};
                     mem_wen_q   <= full_store_d;
                     mem_wdata_q <= full_store_d ? bus.data_req_wdata : '0;
                     state_q     <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (!bus.mem_exception && partial_d) begin
                  rsp_data_q  <= bus.mem_rdata;
                  mem_wen_q   <= 1'b1;
                  mem_wdata_q <= merged_d;
                  state_q     <= S_WRITE;
               end else begin
                  rsp_data_q        <= bus.mem_exception ? '0 : bus.mem_rdata;
                  rsp_exc_q         <= bus.mem_exception;
                  mem_addr_q        <= '0;
                  mem_wen_q         <= 1'b0;
                  mem_wdata_q       <= '0;
                  fetch_rsp_valid_q <= !src_data_q;
                  data_rsp_valid_q  <= src_data_q;
                  state_q           <= S_RESP;
               end
            end
            S_WRITE: begin
               if (bus.mem_exception) begin
                  rsp_data_q <= '0;
                  rsp_exc_q  <= 1'b1;
               end
               mem_addr_q        <= '0;
               mem_wen_q         <= 1'b0;
               mem_wdata_q       <= '0;
               fetch_rsp_valid_q <= !src_data_q;
               data_rsp_valid_q  <= src_data_q;
               state_q           <= S_RESP;
            end
            S_RESP: begin
               rsp_data_q        <= '0;
               rsp_exc_q         <= 1'b0;
               fetch_rsp_valid_q <= 1'b0;
               data_rsp_valid_q  <= 1'b0;
               state_q           <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Ready only in IDLE and never while reset is held; a memory fault on the
   // addressed word suppresses the write in the same cycle.
   always_comb begin
      bus.fetch_req_ready     = (state_q == S_IDLE) && reset && grant_fetch_d;
      bus.data_req_ready      = (state_q == S_IDLE) && reset && grant_data_d;
      bus.fetch_rsp_valid     = fetch_rsp_valid_q;
      bus.fetch_rsp_data      = fetch_rsp_valid_q ? rsp_data_q : '0;
      bus.fetch_rsp_exception = fetch_rsp_valid_q && rsp_exc_q;
      bus.data_rsp_valid      = data_rsp_valid_q;
      bus.data_rsp_rdata      = data_rsp_valid_q ? rsp_data_q : '0;
      bus.data_rsp_exception  = data_rsp_valid_q && rsp_exc_q;
      bus.mem_addr            = mem_addr_q;
      bus.mem_wen             = mem_wen_q && !bus.mem_exception;
      bus.mem_wdata           = mem_wdata_q;
      state_o                 = state_q;
   end
endmodule

// File: tb/tb_memory32_port_arbiter.sv
// Directed bench for memory32_port_arbiter with a small word memory model.
module tb_memory32_port_arbiter;
   logic       clk;
   logic       reset;
   logic [1:0] state_o;

   memory32_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   memory32_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRICT_ALIGN(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: 256 words, addresses 0x300-0x3FF fault
   logic [31:0] mem [0:255];
   logic        pl_en;
   logic [31:0] pl_addr;
   logic [31:0] pl_data;
   int          wen_cnt;
   int          rsp_cnt;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   assign bus.mem_rdata     = mem[bus.mem_addr[9:2]];
   assign bus.mem_exception = (bus.mem_addr[9:8] == 2'b11);

   initial begin
      wen_cnt    = 0;
      rsp_cnt    = 0;
      last_waddr = '0;
      last_wdata = '0;
   end

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr[9:2]] <= pl_data;
      end else if (bus.mem_wen) begin
         mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
         wen_cnt    <= wen_cnt + 1;
         last_waddr <= bus.mem_addr;
         last_wdata <= bus.mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (bus.fetch_rsp_valid || bus.data_rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   // scoreboard counters and checker
   int err_cnt;
   int chk_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic mem_load(input logic [31:0] addr, input logic [31:0] data);
      pl_addr = addr;
      pl_data = data;
      pl_en   = 1'b1;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic drive_fetch(input logic [31:0] addr);
      bus.fetch_req_addr  = addr;
      bus.fetch_req_valid = 1'b1;
   endtask

   task automatic drive_data(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] wmask);
      bus.data_req_addr  = addr;
      bus.data_req_write = wr;
      bus.data_req_wdata = wdata;
      bus.data_req_wmask = wmask;
      bus.data_req_valid = 1'b1;
   endtask

   // Wait for the chosen side's ready; exp_wait is the expected number of
   // falling edges until it shows. The accepted valid is dropped after the edge.
   task automatic accept_wait(input bit is_fetch, input int exp_wait, input string tag);
      int waited;
      bit seen;
      seen   = 1'b0;
      waited = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (is_fetch ? bus.fetch_req_ready : bus.data_req_ready) begin
            seen   = 1'b1;
            waited = n;
            break;
         end
      end
      check({tag, "_ready_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_grant_wait"}, 32'(waited), 32'(exp_wait));
         check({tag, "_other_ready"},
               32'(is_fetch ? bus.data_req_ready : bus.fetch_req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      if (is_fetch) bus.fetch_req_valid = 1'b0;
      else          bus.data_req_valid  = 1'b0;
   endtask

   // Called right after the accepting edge; counts cycles until rsp_valid.
   task automatic wait_rsp(input bit is_fetch, input int exp_lat, input logic [31:0] exp_data,
                           input logic exp_exc, input string tag);
      int lat;
      bit seen;
      seen = 1'b0;
      lat  = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (is_fetch ? bus.fetch_rsp_valid : bus.data_rsp_valid) begin
            seen = 1'b1;
            lat  = n;
            break;
         end
      end
      check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         check({tag, "_data"}, is_fetch ? bus.fetch_rsp_data : bus.data_rsp_rdata, exp_data);
         check({tag, "_exc"}, 32'(is_fetch ? bus.fetch_rsp_exception : bus.data_rsp_exception),
               32'(exp_exc));
         check({tag, "_other_rsp"}, 32'(is_fetch ? bus.data_rsp_valid : bus.fetch_rsp_valid), 32'd0);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   int wen0;
   int rsp0;

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      pl_en   = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      bus.fetch_req_valid = 1'b0;
      bus.fetch_req_addr  = '0;
      bus.data_req_valid  = 1'b0;
      bus.data_req_addr   = '0;
      bus.data_req_write  = 1'b0;
      bus.data_req_wdata  = '0;
      bus.data_req_wmask  = '0;
      reset = 1'b0;

      // reset state: everything 0 even with both requesters valid
      #12;
      drive_fetch(32'h100);
      drive_data(32'h100, 1'b0, 32'h0, 4'h0);
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_fetch_ready", 32'(bus.fetch_req_ready), 32'd0);
      check("rst_data_ready", 32'(bus.data_req_ready), 32'd0);
      check("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_rsp_valid", 32'({bus.fetch_rsp_valid, bus.data_rsp_valid}), 32'd0);
      bus.fetch_req_valid = 1'b0;
      bus.data_req_valid  = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      mem_load(32'h100, 32'hDEADBEEF);
      mem_load(32'h200, 32'h11223344);
      mem_load(32'h204, 32'h55555555);
      apply_reset();

      // arbitration: first tie after reset goes to fetch, then alternates
      @(posedge clk); #1;
      drive_fetch(32'h100);
      drive_data(32'h100, 1'b0, 32'h0, 4'h0);
      accept_wait(1'b1, 1, "arb1_f");
      wait_rsp(1'b1, 2, 32'hDEADBEEF, 1'b0, "arb1_f");
      accept_wait(1'b0, 1, "arb1_d");
      wait_rsp(1'b0, 2, 32'hDEADBEEF, 1'b0, "arb1_d");
      drive_fetch(32'h100);
      drive_data(32'h100, 1'b0, 32'h0, 4'h0);
      accept_wait(1'b1, 1, "arb2_f");
      wait_rsp(1'b1, 2, 32'hDEADBEEF, 1'b0, "arb2_f");
      accept_wait(1'b0, 1, "arb2_d");
      wait_rsp(1'b0, 2, 32'hDEADBEEF, 1'b0, "arb2_d");

      // lone fetch (basic fetch of 0x100), then a tie goes to data
      drive_fetch(32'h100);
      accept_wait(1'b1, 1, "fetch1");
      wait_rsp(1'b1, 2, 32'hDEADBEEF, 1'b0, "fetch1");
      drive_fetch(32'h100);
      drive_data(32'h100, 1'b0, 32'h0, 4'h0);
      accept_wait(1'b0, 1, "arb3_d");
      wait_rsp(1'b0, 2, 32'hDEADBEEF, 1'b0, "arb3_d");
      accept_wait(1'b1, 1, "arb3_f");
      wait_rsp(1'b1, 2, 32'hDEADBEEF, 1'b0, "arb3_f");

      // byte store: read-modify-write
      wen0 = wen_cnt;
      drive_data(32'h200, 1'b1, 32'h000000AA, 4'b0001);
      accept_wait(1'b0, 1, "rmw");
      wait_rsp(1'b0, 3, 32'h11223344, 1'b0, "rmw");
      check("rmw_wen_count", 32'(wen_cnt - wen0), 32'd1);
      check("rmw_waddr", last_waddr, 32'h200);
      check("rmw_wdata", last_wdata, 32'h112233AA);
      check("rmw_mem", mem[8'h80], 32'h112233AA);

      // full-word store then load back
      wen0 = wen_cnt;
      drive_data(32'h204, 1'b1, 32'hCAFEF00D, 4'hF);
      accept_wait(1'b0, 1, "full_st");
      wait_rsp(1'b0, 2, 32'h55555555, 1'b0, "full_st");
      check("full_wen_count", 32'(wen_cnt - wen0), 32'd1);
      check("full_wdata", last_wdata, 32'hCAFEF00D);
      drive_data(32'h204, 1'b0, 32'h0, 4'h0);
      accept_wait(1'b0, 1, "ld_back");
      wait_rsp(1'b0, 2, 32'hCAFEF00D, 1'b0, "ld_back");

      // empty mask store: reads old word, writes nothing
      wen0 = wen_cnt;
      drive_data(32'h200, 1'b1, 32'hFFFFFFFF, 4'h0);
      accept_wait(1'b0, 1, "mask0");
      wait_rsp(1'b0, 2, 32'h112233AA, 1'b0, "mask0");
      check("mask0_wen_count", 32'(wen_cnt - wen0), 32'd0);

      // faults: misaligned load and fetch, memory fault on stores
      wen0 = wen_cnt;
      drive_data(32'h202, 1'b0, 32'h0, 4'h0);
      accept_wait(1'b0, 1, "misal_ld");
      wait_rsp(1'b0, 1, 32'h0, 1'b1, "misal_ld");
      drive_fetch(32'h101);
      accept_wait(1'b1, 1, "misal_f");
      wait_rsp(1'b1, 1, 32'h0, 1'b1, "misal_f");
      drive_data(32'h300, 1'b1, 32'h12345678, 4'hF);
      accept_wait(1'b0, 1, "mexc_full");
      wait_rsp(1'b0, 2, 32'h0, 1'b1, "mexc_full");
      drive_data(32'h304, 1'b1, 32'h12345678, 4'b0100);
      accept_wait(1'b0, 1, "mexc_part");
      wait_rsp(1'b0, 2, 32'h0, 1'b1, "mexc_part");
      drive_fetch(32'h308);
      accept_wait(1'b1, 1, "mexc_f");
      wait_rsp(1'b1, 2, 32'h0, 1'b1, "mexc_f");
      check("fault_wen_count", 32'(wen_cnt - wen0), 32'd0);

      // reset in the WRITE cycle of a byte store aborts it
      mem_load(32'h200, 32'h11223344);
      wen0 = wen_cnt;
      rsp0 = rsp_cnt;
      drive_data(32'h200, 1'b1, 32'h000000AA, 4'b0001);
      accept_wait(1'b0, 1, "abort");
      begin
         bit in_write;
         in_write = 1'b0;
         for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (state_o == 2'd2) begin
               in_write = 1'b1;
               break;
            end
         end
         check("abort_reached_write", 32'(in_write), 32'd1);
      end
      reset = 1'b0;
      #1;
      check("abort_mem_wen", 32'(bus.mem_wen), 32'd0);
      check("abort_mem_addr", bus.mem_addr, 32'd0);
      check("abort_mem_wdata", bus.mem_wdata, 32'd0);
      check("abort_state", 32'(state_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("abort_no_write", 32'(wen_cnt - wen0), 32'd0);
      check("abort_mem_kept", mem[8'h80], 32'h11223344);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
